// File: rtl/param_menu_ctrl_if.sv
// Preset-store read port plus the shared cell load bus.
//   master (controller): drives rd_req/rd_addr, load_valid/load_data, busy, load_done
//   slave  (store/cells): drives rd_ack/rd_data
interface param_menu_ctrl_if #(
  parameter int unsigned NUM_PARAMS  = 8,
  parameter int unsigned IDX_WIDTH   = 3,
  parameter int unsigned PARAM_WIDTH = 8
);
  logic                   rd_req;
  logic [IDX_WIDTH:0]     rd_addr;
  logic                   rd_ack;
  logic [PARAM_WIDTH-1:0] rd_data;
  logic [NUM_PARAMS-1:0]  load_valid;
  logic [PARAM_WIDTH-1:0] load_data;
  logic                   busy;
  logic                   load_done;

  modport master (
    output rd_req, rd_addr, load_valid, load_data, busy, load_done,
    input  rd_ack, rd_data
  );

  modport slave (
    input  rd_req, rd_addr, load_valid, load_data, busy, load_done,
    output rd_ack, rd_data
  );
endinterface

// File: rtl/param_menu_ctrl.sv
// Menu/sequencing controller for a bank of parameter cells: tracks the edited
// cell (one-hot selected), forwards restore, times out of EDIT, and bulk-loads
// every cell from a preset store.
//   clk, resetn      : clock, async active-low reset
//   clk_ms           : 1 kHz square wave (synchronised here)
//   key_*            : debounced 1-cycle key pulses; key_activity is a level
//   load_start       : start a bulk preset load
//   bus              : preset read port + shared cell load bus (master side)
//   selected/sel_idx : one-hot selection in EDIT / current or last index
//   restore          : 1-cycle restore broadcast
module param_menu_ctrl #(
  parameter int unsigned NUM_PARAMS  = 8,
  parameter int unsigned IDX_WIDTH   = 3,
  parameter int unsigned PARAM_WIDTH = 8,
  parameter int unsigned TIMEOUT_MS  = 10000,
  parameter int unsigned ADDR_BASE   = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clk_ms,
  input  logic                  key_next,
  input  logic                  key_prev,
  input  logic                  key_exit,
  input  logic                  key_restore,
  input  logic                  key_activity,
  input  logic                  load_start,
  param_menu_ctrl_if.master     bus,
  output logic [NUM_PARAMS-1:0] selected,
  output logic [IDX_WIDTH-1:0]  sel_idx,
  output logic                  restore
);

  localparam int unsigned ADDR_W = IDX_WIDTH + 1;
  localparam int unsigned TO_W   = (TIMEOUT_MS < 2) ? 1 : $clog2(TIMEOUT_MS + 1);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_PARAMS - 1);
  localparam logic [TO_W-1:0]      TO_LOAD  = TO_W'(TIMEOUT_MS);

  typedef enum logic [2:0] {
    S_IDLE, S_EDIT, S_LOAD_REQ, S_LOAD_WAIT, S_LOAD_WRITE
  } state_t;

  state_t               state;
  logic [2:0]           ms_q;
  logic                 tick_ms;
  logic [TO_W-1:0]      to_cnt;
  logic [IDX_WIDTH-1:0] load_idx;
  logic [IDX_WIDTH-1:0] idx_fwd;
  logic [IDX_WIDTH-1:0] idx_back;
  logic                 step_fwd;
  logic                 step_back;
  logic                 any_key;

  function automatic logic [NUM_PARAMS-1:0] onehot(input logic [IDX_WIDTH-1:0] i);
    return NUM_PARAMS'(1) << i;
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input logic [IDX_WIDTH-1:0] i);
    return ADDR_W'(ADDR_BASE) + ADDR_W'(i);
  endfunction

  // Two-flop synchroniser plus edge-detect flop for the 1 kHz reference
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ms_q <= '0;
    else         ms_q <= {ms_q[1:0], clk_ms};
  end

  assign tick_ms   = ms_q[1] & ~ms_q[2];
  // Simultaneous next and prev cancel each other
  assign step_fwd  = key_next & ~key_prev;
  assign step_back = key_prev & ~key_next;
  assign idx_fwd   = (sel_idx == LAST_IDX) ? '0 : sel_idx + IDX_WIDTH'(1);
  assign idx_back  = (sel_idx == '0) ? LAST_IDX : sel_idx - IDX_WIDTH'(1);
  assign any_key   = key_next | key_prev | key_exit | key_restore | key_activity;

  // Menu / load sequencer with registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= S_IDLE;
      sel_idx        <= '0;
      selected       <= '0;
      restore        <= 1'b0;
      to_cnt         <= TO_LOAD;
      load_idx       <= '0;
      bus.rd_req     <= 1'b0;
      bus.rd_addr    <= addr_of('0);
      bus.load_valid <= '0;
      bus.load_data  <= '0;
      bus.busy       <= 1'b0;
      bus.load_done  <= 1'b0;
    end else begin
      restore        <= 1'b0;
      bus.load_valid <= '0;
      bus.load_done  <= 1'b0;

      // load_start outranks every key, from IDLE and EDIT alike
      if ((state == S_IDLE || state == S_EDIT) && load_start) begin
        state       <= S_LOAD_REQ;
        selected    <= '0;
        load_idx    <= '0;
        bus.rd_req  <= 1'b1;
        bus.rd_addr <= addr_of('0);
        bus.busy    <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            // Entry keeps the current index; it does not step it
            if (key_next || key_prev) begin
              state    <= S_EDIT;
              selected <= onehot(sel_idx);
              to_cnt   <= TO_LOAD;
            end
          end

          S_EDIT: begin
            if (key_exit) begin
              state    <= S_IDLE;
              selected <= '0;
            end else begin
              if (key_restore) begin
                restore <= 1'b1;
              end else if (step_fwd) begin
                sel_idx  <= idx_fwd;
                selected <= onehot(idx_fwd);
              end else if (step_back) begin
                sel_idx  <= idx_back;
                selected <= onehot(idx_back);
              end

              // Exit on the tick after the count is exhausted, giving
              // TIMEOUT_MS..TIMEOUT_MS+1 ms of idle time
              if (any_key) begin
                to_cnt <= TO_LOAD;
              end else if (tick_ms && TIMEOUT_MS != 0) begin
                if (to_cnt == '0) begin
                  state    <= S_IDLE;
                  selected <= '0;
                end else begin
                  to_cnt <= to_cnt - TO_W'(1);
                end
              end
            end
          end

          S_LOAD_REQ: state <= S_LOAD_WAIT;

          S_LOAD_WAIT: begin
            if (bus.rd_ack) begin
              bus.rd_req     <= 1'b0;
              bus.load_data  <= bus.rd_data;
              bus.load_valid <= onehot(load_idx);
              state          <= S_LOAD_WRITE;
            end
          end

          S_LOAD_WRITE: begin
            if (load_idx == LAST_IDX) begin
              bus.load_done <= 1'b1;
              bus.busy      <= 1'b0;
              state         <= S_IDLE;
            end else begin
              load_idx    <= load_idx + IDX_WIDTH'(1);
              bus.rd_req  <= 1'b1;
              bus.rd_addr <= addr_of(load_idx + IDX_WIDTH'(1));
              state       <= S_LOAD_REQ;
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_param_menu_ctrl.sv
// Scoreboard bench for param_menu_ctrl: stimulus pushes expected output events
// (selection changes, restore, load strobes, load_done) into a queue and an
// independent monitor pops and compares them as the DUT produces them.
module tb_param_menu_ctrl;

  localparam int unsigned NP   = 8;
  localparam int unsigned IW   = 3;
  localparam int unsigned PW   = 8;
  localparam int unsigned TMO  = 5;
  localparam int unsigned ACKK = 3;

  localparam logic [1:0] EV_SEL  = 2'd0;
  localparam logic [1:0] EV_RST  = 2'd1;
  localparam logic [1:0] EV_LV   = 2'd2;
  localparam logic [1:0] EV_DONE = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] val;
  } evt_t;

  logic          clk = 1'b0;
  logic          clk_ms = 1'b0;
  logic          resetn = 1'b0;
  logic [5:0]    kp = '0;   // {load_start, key_restore, key_exit, key_prev, key_next} in [4:0]
  logic          activity = 1'b0;
  logic [NP-1:0] selected;
  logic [IW-1:0] sel_idx;
  logic          restore;

  int   vectors = 0;
  int   miscompares = 0;
  int   ack_cnt = 0;
  int   cyc = 0;
  evt_t exp_q[$];
  int   lv_cyc[$];
  logic [NP-1:0] sel_prev = '0;

  param_menu_ctrl_if #(.NUM_PARAMS(NP), .IDX_WIDTH(IW), .PARAM_WIDTH(PW)) ifc ();

  param_menu_ctrl #(
    .NUM_PARAMS(NP), .IDX_WIDTH(IW), .PARAM_WIDTH(PW),
    .TIMEOUT_MS(TMO), .ADDR_BASE(0)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .clk_ms       (clk_ms),
    .key_next     (kp[0]),
    .key_prev     (kp[1]),
    .key_exit     (kp[2]),
    .key_restore  (kp[3]),
    .key_activity (activity),
    .load_start   (kp[4]),
    .bus          (ifc.master),
    .selected     (selected),
    .sel_idx      (sel_idx),
    .restore      (restore)
  );

  always #5 clk = ~clk;
  // Scaled 1 kHz reference: 40 clk cycles per "ms", offset away from clk edges
  initial begin
    #3;
    forever #200 clk_ms = ~clk_ms;
  end
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [5:0] K_NEXT = 6'b000001;
  localparam logic [5:0] K_PREV = 6'b000010;
  localparam logic [5:0] K_EXIT = 6'b000100;
  localparam logic [5:0] K_RST  = 6'b001000;
  localparam logic [5:0] K_LOAD = 6'b010000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic check_evt(input logic [1:0] kind, input logic [15:0] val);
    evt_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_event: got kind %0d val 0x%0h at cycle %0d, expected none", kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== kind || e.val !== val) begin
        miscompares++;
        $display("FAIL event: got kind %0d val 0x%0h at cycle %0d, expected kind %0d val 0x%0h",
                 kind, val, cyc, e.kind, e.val);
      end
    end
  endtask

  // Monitor: every observable output event is compared against the queue
  always @(negedge clk) begin
    if (!resetn) begin
      sel_prev = selected;
    end else begin
      if (selected != sel_prev) check_evt(EV_SEL, {5'b0, sel_idx, selected});
      sel_prev = selected;
      if (restore) check_evt(EV_RST, 16'h0);
      if (ifc.load_valid != '0) begin
        check_evt(EV_LV, {ifc.load_valid, ifc.load_data});
        lv_cyc.push_back(cyc);
      end
      if (ifc.load_done) check_evt(EV_DONE, 16'h0);
    end
  end

  // Preset store model: acks ACKK cycles after rd_req rises, data = 0x10 + addr
  initial begin
    logic [IW:0] a;
    ifc.rd_ack  = 1'b0;
    ifc.rd_data = '0;
    forever begin
      @(negedge clk);
      if (resetn && ifc.rd_req) begin
        a = ifc.rd_addr;
        repeat (ACKK) @(posedge clk);
        if (resetn && ifc.rd_req) begin
          chk("rd_addr_stable", 32'(ifc.rd_addr), 32'(a));
          #1;
          ifc.rd_ack  = 1'b1;
          ifc.rd_data = 8'h10 + 8'(a);
          ack_cnt++;
          @(posedge clk);
          #1 ifc.rd_ack = 1'b0;
        end
      end
    end
  end

  task automatic pulse(input logic [5:0] v);
    kp = v;
    @(posedge clk);
    #1 kp = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_sel(input int idx, input bit on);
    evt_t e;
    logic [NP-1:0] oh;
    oh = on ? NP'(1) << idx : '0;
    e.kind = EV_SEL;
    e.val  = {5'b0, IW'(idx), oh};
    exp_q.push_back(e);
  endtask

  task automatic exp_evt(input logic [1:0] kind, input logic [15:0] val);
    evt_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic exp_load(input int n);
    for (int i = 0; i < n; i++) exp_evt(EV_LV, {8'(1 << i), 8'h10 + 8'(i)});
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1 n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d events still outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    int busy_bad = 0;
    while (!ifc.load_done && n < budget) begin
      @(negedge clk);
      if (!ifc.load_done && ifc.busy !== 1'b1) busy_bad++;
      n++;
    end
    chk("load_done_seen", 32'(ifc.load_done), 32'd1);
    chk("busy_high_during_load", 32'(busy_bad), 32'd0);
    chk("busy_low_with_done", 32'(ifc.busy), 32'd0);
    #1;
  endtask

  initial begin
    #(50000 * 10);
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    int edges;
    int n;
    int bad;
    logic ms_prev;

    // Reset values
    idle(3);
    @(negedge clk);
    chk("rst_selected", 32'(selected), 32'd0);
    chk("rst_sel_idx", 32'(sel_idx), 32'd0);
    chk("rst_rd_req", 32'(ifc.rd_req), 32'd0);
    chk("rst_rd_addr", 32'(ifc.rd_addr), 32'd0);
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    chk("rst_outs", 32'({ifc.load_valid, ifc.load_data, restore, ifc.load_done}), 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    idle(4);

    // Wrap-around: entry keeps idx 0, forward wrap, backward wrap
    exp_sel(0, 1);
    pulse(K_NEXT);
    for (int i = 1; i < 8; i++) begin
      exp_sel(i, 1);
      pulse(K_NEXT);
    end
    exp_sel(0, 1);
    pulse(K_NEXT);
    exp_sel(7, 1);
    pulse(K_PREV);
    drain(10);
    chk("wrap_selected", 32'(selected), 32'h80);

    // Walk to idx 3, simultaneous next+prev ignored, restore, exit priority
    for (int i = 0; i < 4; i++) begin
      exp_sel(i, 1);
      pulse(K_NEXT);
    end
    pulse(K_NEXT | K_PREV);
    exp_evt(EV_RST, 16'h0);
    pulse(K_RST);
    idle(3);
    drain(10);
    chk("restore_selected", 32'(selected), 32'h08);
    exp_sel(3, 0);
    pulse(K_EXIT);
    drain(10);
    chk("exit_sel_idx", 32'(sel_idx), 32'd3);
    exp_sel(3, 1);
    pulse(K_NEXT);
    exp_sel(3, 0);
    pulse(K_EXIT | K_RST);
    idle(3);
    drain(10);

    // Timeout with no activity: exit after 5..6 ms ticks
    @(posedge clk_ms);
    idle(10);
    exp_sel(3, 1);
    exp_sel(3, 0);
    pulse(K_NEXT);
    edges = 0;
    n = 0;
    ms_prev = clk_ms;
    while (selected != '0 && n < 400) begin
      @(negedge clk);
      if (clk_ms && !ms_prev) edges++;
      ms_prev = clk_ms;
      n++;
    end
    vectors++;
    if (selected != '0 || edges < 5 || edges > 6) begin
      miscompares++;
      $display("FAIL timeout_exit: got %0d ms edges (selected 0x%0h), expected 5..6 and 0x0", edges, selected);
    end
    drain(10);

    // Held activity keeps EDIT alive for 20 ms, then it times out
    exp_sel(3, 1);
    pulse(K_NEXT);
    activity = 1'b1;
    bad = 0;
    repeat (800) begin
      @(negedge clk);
      if (selected != 8'h08) bad++;
    end
    chk("activity_holds_edit", 32'(bad), 32'd0);
    #1 activity = 1'b0;
    exp_sel(3, 0);
    drain(400);

    // Bulk load from IDLE: 8 strobes in order, k+2 cycles each
    lv_cyc.delete();
    exp_load(8);
    exp_evt(EV_DONE, 16'h0);
    pulse(K_LOAD);
    @(negedge clk);
    chk("rd_req_after_start", 32'(ifc.rd_req), 32'd1);
    chk("busy_after_start", 32'(ifc.busy), 32'd1);
    wait_done(100);
    drain(10);
    bad = 0;
    for (int i = 1; i < lv_cyc.size(); i++) if (lv_cyc[i] - lv_cyc[i-1] != ACKK + 2) bad++;
    chk("load_strobe_count", 32'(lv_cyc.size()), 32'd8);
    chk("load_period", 32'(bad), 32'd0);
    chk("load_keeps_sel_idx", 32'(sel_idx), 32'd3);
    idle(10);

    // load_start beats key_next from EDIT; keys and load_start locked out
    exp_sel(3, 1);
    pulse(K_NEXT);
    drain(10);
    exp_sel(3, 0);
    exp_load(8);
    exp_evt(EV_DONE, 16'h0);
    pulse(K_LOAD | K_NEXT);
    idle(4);
    pulse(K_NEXT);
    idle(6);
    pulse(K_RST | K_PREV);
    idle(6);
    pulse(K_LOAD);
    idle(3);
    pulse(K_NEXT);
    wait_done(100);
    drain(10);
    chk("lockout_sel_idx", 32'(sel_idx), 32'd3);
    idle(60);
    exp_sel(3, 1);
    pulse(K_NEXT);
    drain(10);
    exp_sel(3, 0);
    pulse(K_EXIT);
    drain(10);

    // Reset in LOAD_WAIT after the 3rd acknowledge
    ack_cnt = 0;
    exp_load(3);
    pulse(K_LOAD);
    n = 0;
    while (ifc.load_valid != 8'h04 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("third_strobe_seen", 32'(ifc.load_valid), 32'h04);
    @(posedge clk);
    @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("midload_ack_count", 32'(ack_cnt), 32'd3);
    chk("midload_rd_req", 32'(ifc.rd_req), 32'd0);
    chk("midload_load_valid", 32'(ifc.load_valid), 32'd0);
    chk("midload_busy", 32'(ifc.busy), 32'd0);
    chk("midload_rd_addr", 32'(ifc.rd_addr), 32'd0);
    drain(2);
    idle(4);
    resetn = 1'b1;
    idle(3);
    chk("post_reset_sel_idx", 32'(sel_idx), 32'd0);
    chk("post_reset_selected", 32'(selected), 32'd0);
    exp_sel(0, 1);
    pulse(K_NEXT);
    drain(10);
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
